step_seq_monitor: RTL and testbench
===================================

STEP_SEQ_MONITOR -- requirements
Module: step_seq_monitor

Interface
REQ-001 The block SHALL have parameter IO_SIZE_G, default 3, width of the monitored state word.
REQ-002 The block SHALL have parameters IDLE=0, S1_C=3, S2_C=6, ERROR=7 (each IO_SIZE_G bits), the state encodings to decode.
REQ-003 The block SHALL have parameter CNT_WIDTH_G, default 16, width of each event counter.
REQ-004 The block SHALL have parameter FIFO_DEPTH_G, default 4 (power of two, >=2), the event FIFO depth.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n_i, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 The block SHALL have port state_i, input, IO_SIZE_G bits, the voted state word of the upstream step FSM, sampled every cycle.
REQ-008 The block SHALL have port clear_i, input, 1 bit, synchronous clear of counters, FIFO and overflow flag.
REQ-009 The block SHALL have port evt_valid_o, output, 1 bit, FIFO head holds an event.
REQ-010 The block SHALL have port evt_code_o, output, 2 bits, head event code: 01=S1 done, 10=S2 done, 11=error, 00 when empty.
REQ-011 The block SHALL have port evt_ready_i, input, 1 bit, consumer accepts head when high together with evt_valid_o.
REQ-012 The block SHALL have ports s1_cnt_o, s2_cnt_o and err_cnt_o, output, CNT_WIDTH_G bits each, the event counters.
REQ-013 The block SHALL have port fifo_level_o, output, $clog2(FIFO_DEPTH_G)+1 bits, number of stored events.
REQ-014 The block SHALL have port overflow_o, output, 1 bit, sticky flag set when an event is dropped.

Function
REQ-015 The block SHALL hold a previous-state register prev_q, loaded with state_i every cycle.
REQ-016 The block SHALL detect S1 done when state_i==S1_C and prev_q!=S1_C, S2 done when state_i==S2_C and prev_q!=S2_C, and error when state_i==ERROR and prev_q!=ERROR; at most one event occurs per cycle.
REQ-017 The block SHALL update the matching counter at the same rising edge that samples the triggering state_i (1-cycle latency to the output).
REQ-018 The counters SHALL saturate at all-ones; an event at saturation leaves the counter unchanged.
REQ-019 The FIFO SHALL push the event code at the same edge that updates the counter, so evt_valid_o rises one cycle after the triggering state_i when the FIFO was empty.
REQ-020 A pop SHALL occur at a rising edge where evt_valid_o and evt_ready_i are both high; evt_code_o then shows the next entry, or 00 when empty.
REQ-021 evt_valid_o and evt_code_o SHALL be register-driven and SHALL stay stable while evt_valid_o=1 and evt_ready_i=0.
REQ-022 When the FIFO is full and an event occurs together with a pop, the push SHALL be accepted and fifo_level_o SHALL stay FIFO_DEPTH_G.
REQ-023 When the FIFO is full and an event occurs without a pop, the event SHALL be dropped from the FIFO, its counter SHALL still increment, and overflow_o SHALL be set.
REQ-024 When the FIFO is empty, a pop attempt SHALL have no effect and a push SHALL proceed normally.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH_G; fifo_level_o SHALL equal pushes minus pops.
REQ-026 clear_i=1 SHALL zero the counters, empty the FIFO and clear overflow_o at the next edge, and clear SHALL take priority over any same-cycle event or pop.
REQ-027 clear_i SHALL NOT reset prev_q, so edge detection continues across a clear.
REQ-028 Unlisted state encodings SHALL produce no event.

Reset
REQ-029 Asserting rst_n_i low SHALL immediately set prev_q=IDLE, all counters=0, FIFO empty, evt_valid_o=0, evt_code_o=00, fifo_level_o=0 and overflow_o=0, regardless of clk_i.
REQ-030 Reset asserted mid-operation SHALL discard all stored events, and the first edge after release SHALL compare against prev_q=IDLE.

Verification
REQ-031 The bench SHALL cover: state_i sequence 0,1,2,3,3,0 -> s1_cnt_o=1 one cycle after the first 3, evt_code_o=01, evt_valid_o=1, fifo_level_o=1.
REQ-032 The bench SHALL cover: evt_ready_i=0 with alternating 0/7 on state_i for 5 error entries -> err_cnt_o=5, fifo_level_o=4, overflow_o=1.
REQ-033 The bench SHALL cover: FIFO full with a S2_C entry and evt_ready_i=1 in the same cycle -> fifo_level_o stays 4, the tail entry is 10, and overflow_o stays 0.
REQ-034 The bench SHALL cover: CNT_WIDTH_G=4 with 17 S1 completions -> s1_cnt_o=15 saturated.
REQ-035 The bench SHALL cover: clear_i=1 in the same cycle as an ERROR entry -> err_cnt_o=0, fifo_level_o=0, overflow_o=0.
REQ-036 The bench SHALL cover: rst_n_i pulsed low between clock edges with 3 events stored -> all outputs zero at once; after release, state_i held at 7 -> one error event.

Source files
------------

// File: rtl/step_seq_monitor.sv
// rtl/step_seq_monitor.sv - edge-detects step FSM completions/errors, counts them and queues event codes
module step_seq_monitor #(
  parameter int                   IO_SIZE_G    = 3,
  parameter logic [IO_SIZE_G-1:0] IDLE         = '0,
  parameter logic [IO_SIZE_G-1:0] S1_C         = IO_SIZE_G'(3),
  parameter logic [IO_SIZE_G-1:0] S2_C         = IO_SIZE_G'(6),
  parameter logic [IO_SIZE_G-1:0] ERROR        = IO_SIZE_G'(7),
  parameter int                   CNT_WIDTH_G  = 16,
  parameter int                   FIFO_DEPTH_G = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [IO_SIZE_G-1:0]            state_i,
  input  logic                            clear_i,
  output logic                            evt_valid_o,
  output logic [1:0]                      evt_code_o,
  input  logic                            evt_ready_i,
  output logic [CNT_WIDTH_G-1:0]          s1_cnt_o,
  output logic [CNT_WIDTH_G-1:0]          s2_cnt_o,
  output logic [CNT_WIDTH_G-1:0]          err_cnt_o,
  output logic [$clog2(FIFO_DEPTH_G):0]   fifo_level_o,
  output logic                            overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH_G);
  localparam int LW = AW + 1;

  logic [IO_SIZE_G-1:0] prev_q;
  logic                 s1_evt, s2_evt, err_evt, evt;
  logic [1:0]           evt_code;
  logic [1:0]           mem_q [FIFO_DEPTH_G];
  logic [AW-1:0]        wr_q, rd_q, rd_n;
  logic [LW-1:0]        count_q, count_n;
  logic                 full, pop, push;
  logic [1:0]           head_n;

  // Encodings are distinct, so at most one of these fires per cycle.
  always_comb begin
    s1_evt  = (state_i == S1_C)  && (prev_q != S1_C);
    s2_evt  = (state_i == S2_C)  && (prev_q != S2_C);
    err_evt = (state_i == ERROR) && (prev_q != ERROR);
    evt     = s1_evt | s2_evt | err_evt;
    evt_code = 2'b00;
    if (s1_evt)       evt_code = 2'b01;
    else if (s2_evt)  evt_code = 2'b10;
    else if (err_evt) evt_code = 2'b11;
  end

  always_comb begin
    full = (count_q == LW'(FIFO_DEPTH_G));
    pop  = evt_valid_o & evt_ready_i;
    push = evt & (~full | pop);
    rd_n = pop ? rd_q + AW'(1) : rd_q;
    count_n = count_q;
    if (push && !pop)      count_n = count_q + LW'(1);
    else if (!push && pop) count_n = count_q - LW'(1);
    // The new head is the entry being written now when nothing older survives the pop.
    if (count_n == '0)
      head_n = 2'b00;
    else if ((count_q == '0) || ((count_q == LW'(1)) && pop))
      head_n = evt_code;
    else
      head_n = mem_q[rd_n];
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) mem_q[wr_q] <= evt_code;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q      <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      evt_valid_o <= 1'b0;
      evt_code_o  <= 2'b00;
      overflow_o  <= 1'b0;
      s1_cnt_o    <= '0;
      s2_cnt_o    <= '0;
      err_cnt_o   <= '0;
    end else begin
      prev_q <= state_i;
      if (clear_i) begin
        wr_q        <= '0;
        rd_q        <= '0;
        count_q     <= '0;
        evt_valid_o <= 1'b0;
        evt_code_o  <= 2'b00;
        overflow_o  <= 1'b0;
        s1_cnt_o    <= '0;
        s2_cnt_o    <= '0;
        err_cnt_o   <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        rd_q        <= rd_n;
        count_q     <= count_n;
        evt_valid_o <= (count_n != '0);
        evt_code_o  <= head_n;
        if (evt && !push) overflow_o <= 1'b1;
        if (s1_evt && (s1_cnt_o != '1))   s1_cnt_o  <= s1_cnt_o + CNT_WIDTH_G'(1);
        if (s2_evt && (s2_cnt_o != '1))   s2_cnt_o  <= s2_cnt_o + CNT_WIDTH_G'(1);
        if (err_evt && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + CNT_WIDTH_G'(1);
      end
    end
  end

  assign fifo_level_o = count_q;

endmodule

// File: tb/tb_step_seq_monitor.sv
// tb/tb_step_seq_monitor.sv - vector table plus queue scoreboard for step_seq_monitor
module tb_step_seq_monitor;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_n_i, clear_i, evt_ready_i;
  logic [2:0] state_i;
  logic       evt_valid_o, overflow_o;
  logic [1:0] evt_code_o;
  logic [15:0] s1_cnt_o, s2_cnt_o, err_cnt_o;
  logic [2:0] fifo_level_o;
  logic       valid4, ovf4;
  logic [1:0] code4;
  logic [3:0] s1_4, s2_4, err_4;
  logic [2:0] lvl4;

  step_seq_monitor dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .state_i(state_i), .clear_i(clear_i),
    .evt_valid_o(evt_valid_o), .evt_code_o(evt_code_o), .evt_ready_i(evt_ready_i),
    .s1_cnt_o(s1_cnt_o), .s2_cnt_o(s2_cnt_o), .err_cnt_o(err_cnt_o),
    .fifo_level_o(fifo_level_o), .overflow_o(overflow_o)
  );

  step_seq_monitor #(.CNT_WIDTH_G(4)) dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .state_i(state_i), .clear_i(clear_i),
    .evt_valid_o(valid4), .evt_code_o(code4), .evt_ready_i(evt_ready_i),
    .s1_cnt_o(s1_4), .s2_cnt_o(s2_4), .err_cnt_o(err_4),
    .fifo_level_o(lvl4), .overflow_o(ovf4)
  );

  typedef struct {
    logic [2:0] st; logic clr; logic rdy;
    int s1; int s2; int err; int lvl; int code; logic vld; logic ovf;
  } vec_t;
  vec_t vecs[$];

  int total = 0;
  int bad   = 0;

  logic [2:0] m_prev;
  int         m_s1, m_s2, m_err;
  logic       m_ovf;
  logic [1:0] sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    m_prev = 3'd0; m_s1 = 0; m_s2 = 0; m_err = 0; m_ovf = 1'b0;
    sbq.delete();
  endtask

  task automatic model_edge(input logic [2:0] st, input logic clr, input logic rdy);
    logic [1:0] e;
    logic       pop, full;
    if (clr) begin
      m_s1 = 0; m_s2 = 0; m_err = 0; m_ovf = 1'b0;
      sbq.delete();
    end else begin
      e = 2'd0;
      if (st == 3'd3 && m_prev != 3'd3) e = 2'd1;
      else if (st == 3'd6 && m_prev != 3'd6) e = 2'd2;
      else if (st == 3'd7 && m_prev != 3'd7) e = 2'd3;
      if (e == 2'd1) m_s1 = sat16(m_s1);
      if (e == 2'd2) m_s2 = sat16(m_s2);
      if (e == 2'd3) m_err = sat16(m_err);
      full = (sbq.size() == 4);
      pop  = rdy && (sbq.size() > 0);
      if (pop) void'(sbq.pop_front());
      if (e != 2'd0) begin
        if (!full || pop) sbq.push_back(e);
        else m_ovf = 1'b1;
      end
    end
    m_prev = st;
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".valid"}, 32'(evt_valid_o), 32'(sbq.size() > 0));
    chk({tag, ".code"},  32'(evt_code_o),  (sbq.size() > 0) ? 32'(sbq[0]) : 32'd0);
    chk({tag, ".level"}, 32'(fifo_level_o), 32'(sbq.size()));
    chk({tag, ".s1"},    32'(s1_cnt_o),  32'(m_s1));
    chk({tag, ".s2"},    32'(s2_cnt_o),  32'(m_s2));
    chk({tag, ".err"},   32'(err_cnt_o), 32'(m_err));
    chk({tag, ".ovf"},   32'(overflow_o), 32'(m_ovf));
  endtask

  task automatic step(input logic [2:0] st, input logic clr, input logic rdy, input string tag);
    state_i = st; clear_i = clr; evt_ready_i = rdy;
    if (!clr && rdy && sbq.size() > 0)
      chk({tag, ".popped_code"}, 32'(evt_code_o), 32'(sbq[0]));
    @(posedge clk_i);
    model_edge(st, clr, rdy);
    #1;
    model_check(tag);
  endtask

  function automatic void add(input logic [2:0] st, input logic clr, input logic rdy,
                              input int s1, input int s2, input int err, input int lvl,
                              input int code, input logic vld, input logic ovf);
    vec_t v;
    v.st = st; v.clr = clr; v.rdy = rdy; v.s1 = s1; v.s2 = s2; v.err = err;
    v.lvl = lvl; v.code = code; v.vld = vld; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    // state sequence 0,1,2,3,3,0 then clear
    add(0,0,0, 0,0,0, 0,0,0,0);
    add(1,0,0, 0,0,0, 0,0,0,0);
    add(2,0,0, 0,0,0, 0,0,0,0);
    add(3,0,0, 1,0,0, 1,1,1,0);
    add(3,0,0, 1,0,0, 1,1,1,0);
    add(0,0,0, 1,0,0, 1,1,1,0);
    add(0,1,0, 0,0,0, 0,0,0,0);
    // five error entries with no consumer
    add(7,0,0, 0,0,1, 1,3,1,0);
    add(0,0,0, 0,0,1, 1,3,1,0);
    add(7,0,0, 0,0,2, 2,3,1,0);
    add(0,0,0, 0,0,2, 2,3,1,0);
    add(7,0,0, 0,0,3, 3,3,1,0);
    add(0,0,0, 0,0,3, 3,3,1,0);
    add(7,0,0, 0,0,4, 4,3,1,0);
    add(0,0,0, 0,0,4, 4,3,1,0);
    add(7,0,0, 0,0,5, 4,3,1,1);
    add(0,1,0, 0,0,0, 0,0,0,0);
    // fill, then push S2 together with a pop while full, then drain
    add(7,0,0, 0,0,1, 1,3,1,0);
    add(0,0,0, 0,0,1, 1,3,1,0);
    add(7,0,0, 0,0,2, 2,3,1,0);
    add(0,0,0, 0,0,2, 2,3,1,0);
    add(7,0,0, 0,0,3, 3,3,1,0);
    add(0,0,0, 0,0,3, 3,3,1,0);
    add(7,0,0, 0,0,4, 4,3,1,0);
    add(0,0,0, 0,0,4, 4,3,1,0);
    add(6,0,1, 0,1,4, 4,3,1,0);
    add(0,0,1, 0,1,4, 3,3,1,0);
    add(0,0,1, 0,1,4, 2,3,1,0);
    add(0,0,1, 0,1,4, 1,2,1,0);
    add(0,0,1, 0,1,4, 0,0,0,0);
    // clear coinciding with an ERROR entry; prev survives the clear
    add(7,0,0, 0,1,5, 1,3,1,0);
    add(0,0,0, 0,1,5, 1,3,1,0);
    add(7,1,0, 0,0,0, 0,0,0,0);
    add(7,0,0, 0,0,0, 0,0,0,0);
    add(0,0,0, 0,0,0, 0,0,0,0);

    rst_n_i = 1'b0; state_i = 3'd0; clear_i = 1'b0; evt_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    model_check("reset");
    chk("reset.w4_s1", 32'(s1_4), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vecs[i].st, vecs[i].clr, vecs[i].rdy, t);
      chk({t, ".tbl_s1"},    32'(s1_cnt_o),     32'(vecs[i].s1));
      chk({t, ".tbl_s2"},    32'(s2_cnt_o),     32'(vecs[i].s2));
      chk({t, ".tbl_err"},   32'(err_cnt_o),    32'(vecs[i].err));
      chk({t, ".tbl_level"}, 32'(fifo_level_o), 32'(vecs[i].lvl));
      chk({t, ".tbl_code"},  32'(evt_code_o),   32'(vecs[i].code));
      chk({t, ".tbl_valid"}, 32'(evt_valid_o),  32'(vecs[i].vld));
      chk({t, ".tbl_ovf"},   32'(overflow_o),   32'(vecs[i].ovf));
    end

    // 17 S1 completions: 4-bit counter saturates at 15
    step(0, 1, 0, "sat_clr");
    for (int i = 0; i < 17; i++) begin
      step(3, 0, 1, "sat_hi");
      step(0, 0, 1, "sat_lo");
    end
    chk("sat.w4_s1", 32'(s1_4), 32'd15);
    chk("sat.w16_s1", 32'(s1_cnt_o), 32'd17);

    // three events stored, then asynchronous reset between edges
    step(0, 1, 0, "rst_clr");
    step(7, 0, 0, "rst_a");
    step(0, 0, 0, "rst_b");
    step(3, 0, 0, "rst_c");
    step(0, 0, 0, "rst_d");
    step(6, 0, 0, "rst_e");
    chk("rst.level_before", 32'(fifo_level_o), 32'd3);
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    model_check("rst_async");
    chk("rst_async.w4_s1", 32'(s1_4), 32'd0);
    state_i = 3'd7;
    #1;
    rst_n_i = 1'b1;
    step(7, 0, 0, "post_rst1");
    chk("post_rst1.err", 32'(err_cnt_o), 32'd1);
    chk("post_rst1.code", 32'(evt_code_o), 32'd3);
    step(7, 0, 0, "post_rst2");
    chk("post_rst2.err", 32'(err_cnt_o), 32'd1);
    chk("post_rst2.level", 32'(fifo_level_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
